// File: rtl/coffee_io_pkg.sv
// Shared definitions for the coffee I/O peripherals: UART transmit FSM
// encoding, default bus addresses and the status-word layout.
package coffee_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic [15:0] DEFAULT_ADDR_DATA = 16'hFFFE;
  localparam logic [15:0] DEFAULT_ADDR_STAT = 16'hFFFD;
  localparam int          STAT_CLR_OVF_BIT  = 3;

  function automatic logic [31:0] pack_status(input logic overflow, input logic full,
                                              input logic empty, input logic busy);
    return {28'b0, overflow, full, empty, busy};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter; the head entry is readable
// combinationally so a pop can capture it on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign dout  = mem[rd_ptr_reg];

  // A push into a full FIFO is still taken when the same cycle frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: bus writes queue bytes in a FIFO and a
// four-state FSM serialises them LSB first.
module uart_tx_port
  import coffee_io_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] ADDR_DATA    = DEFAULT_ADDR_DATA,
  parameter logic [15:0] ADDR_STAT    = DEFAULT_ADDR_STAT
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] status,
  output logic        tx,
  output logic        busy
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t   state_reg;
  logic        tx_reg;
  logic [15:0] baud_reg;
  logic [2:0]  bit_idx_reg;
  logic [7:0]  shift_reg;
  logic        line_busy_reg;
  logic        overflow_reg;

  logic        wr_data;
  logic        clr_ovf;
  logic        push;
  logic        pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] unused_fifo_count;
  logic        unused_data_hi;

  assign wr_data        = wren && (address == ADDR_DATA);
  assign clr_ovf        = wren && (address == ADDR_STAT) && data[STAT_CLR_OVF_BIT];
  assign push           = wr_data && !rst;
  assign pop            = (state_reg == ST_IDLE) && !fifo_empty;
  assign unused_data_hi = ^data[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .srst  (rst),
    .push  (push),
    .pop   (pop),
    .din   (data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  // tx lags the state by one edge, so line_busy_reg keeps busy up through the
  // final stop-bit cycle after the FSM has already returned to IDLE.
  assign busy   = (state_reg != ST_IDLE) || line_busy_reg || !fifo_empty;
  assign tx     = tx_reg;
  assign status = pack_status(overflow_reg, fifo_full, fifo_empty, busy);

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      tx_reg        <= 1'b1;
      baud_reg      <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      line_busy_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      line_busy_reg <= (state_reg != ST_IDLE);

      if (wr_data && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end else if (clr_ovf) begin
        overflow_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          tx_reg      <= 1'b1;
          baud_reg    <= '0;
          bit_idx_reg <= '0;
          if (!fifo_empty) begin
            shift_reg <= fifo_dout;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          tx_reg <= 1'b0;
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= '0;
            state_reg <= ST_DATA;
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
        ST_DATA: begin
          tx_reg <= shift_reg[bit_idx_reg];
          if (baud_reg == BAUD_LAST) begin
            baud_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              bit_idx_reg <= '0;
              state_reg   <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
        ST_STOP: begin
          tx_reg <= 1'b1;
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= '0;
            state_reg <= ST_IDLE;
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with 4 clocks per bit and a 4-entry FIFO;
// expected line patterns and status words are worked out by hand.
`timescale 1ns/1ps
module tb_uart_tx_port;

  localparam logic [15:0] A_DATA = 16'hFFFE;
  localparam logic [15:0] A_STAT = 16'hFFFD;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] address = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] status;
  logic        tx;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_port #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4),
    .ADDR_DATA    (A_DATA),
    .ADDR_STAT    (A_STAT)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .address (address),
    .data    (data),
    .wren    (wren),
    .status  (status),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    address = a;
    data    = d;
    wren    = 1'b1;
    tick();
    wren    = 1'b0;
    address = '0;
    data    = '0;
    $display("write addr=%h data=%h -> status=%h tx=%b", a, d, status, tx);
  endtask

  // Call with the first start-bit cycle already on the line; returns one
  // cycle after the last stop-bit cycle.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic exp;
    int   bad = 0;
    for (int i = 0; i < 10; i++) begin
      exp = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (tx !== exp || busy !== 1'b1) begin
          miscompares++;
          bad++;
          if (bad <= 4)
            $display("FAIL %s bit%0d cyc%0d: tx=%b busy=%b, required tx=%b busy=1",
                     tag, i, j, tx, busy, exp);
        end
        tick();
      end
    end
    $display("frame %s byte=%h checked", tag, b);
  endtask

  task automatic wait_start(input int budget, input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL %s start: tx=%b after %0d cycles, required 0", tag, tx, n);
    end
  endtask

  task automatic check_quiet(input int cycles, input string tag);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx !== 1'b1) bad++;
      tick();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s quiet: tx low %0d of %0d cycles, required 0", tag, bad, cycles);
    end
  endtask

  task automatic check_status(input logic [31:0] exp, input string tag);
    vectors++;
    if (status !== exp) begin
      miscompares++;
      $display("FAIL %s status: got %h, required %h", tag, status, exp);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    address = A_DATA;
    data    = 32'h0000_0000;
    wren    = 1'b1;
    tick();
    rst  = 1'b0;
    wren = 1'b0;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset outputs: tx=%b busy=%b, required tx=1 busy=0", tx, busy);
    end
    check_status(32'h2, "reset");
    check_quiet(12, "reset_write_lost");
    check_status(32'h2, "reset_after");
  endtask

  task automatic test_single();
    bus_write(A_DATA, 32'h0000_0055);
    check_status(32'h1, "single_queued");
    tick();
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL single_latency_e1: tx=%b, required 1", tx);
    end
    tick();
    check_frame(8'h55, "single");
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: tx=%b busy=%b, required tx=1 busy=0", tx, busy);
    end
    check_status(32'h2, "single_end");
  endtask

  task automatic test_back_to_back();
    bus_write(A_DATA, 32'h0000_00A3);
    bus_write(A_DATA, 32'h0000_000F);
    check_status(32'h1, "b2b_queued");
    tick();
    check_frame(8'hA3, "b2b_first");
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_gap: tx=%b busy=%b, required tx=1 busy=1", tx, busy);
    end
    tick();
    check_frame(8'h0F, "b2b_second");
    check_status(32'h2, "b2b_end");
  endtask

  task automatic test_no_effect();
    bus_write(16'hFFFF, 32'h0000_005A);
    bus_write(A_STAT, 32'h0000_0000);
    check_status(32'h2, "no_effect");
    check_quiet(20, "no_effect");
    check_status(32'h2, "no_effect_after");
  endtask

  task automatic test_overflow();
    bus_write(A_DATA, 32'h0000_00FF);
    bus_write(A_DATA, 32'h0000_0022);
    bus_write(A_DATA, 32'h0000_0033);
    bus_write(A_DATA, 32'h0000_0044);
    bus_write(A_DATA, 32'h0000_0055);
    bus_write(A_DATA, 32'h0000_0066);
    check_status(32'hD, "ovf_set");
    bus_write(A_STAT, 32'hFFFF_FFF7);
    check_status(32'hD, "ovf_keep");
    bus_write(A_STAT, 32'h0000_0008);
    check_status(32'h5, "ovf_clear");
    repeat (34) tick();
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_stop_bit: tx=%b, required 1", tx);
    end
    check_status(32'h5, "ovf_pre_pop");
    bus_write(A_DATA, 32'h0000_0077);
    check_status(32'h5, "ovf_push_pop_full");
    wait_start(8, "ovf_f2");
    check_frame(8'h22, "ovf_f2");
    wait_start(8, "ovf_f3");
    check_frame(8'h33, "ovf_f3");
    wait_start(8, "ovf_f4");
    check_frame(8'h44, "ovf_f4");
    wait_start(8, "ovf_f5");
    check_frame(8'h55, "ovf_f5");
    wait_start(8, "ovf_f6");
    check_frame(8'h77, "ovf_f6");
    check_quiet(60, "ovf_drained");
    check_status(32'h2, "ovf_end");
  endtask

  task automatic test_reset_mid_frame();
    bus_write(A_DATA, 32'h0000_00A5);
    bus_write(A_DATA, 32'h0000_003C);
    bus_write(A_DATA, 32'h0000_00C3);
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_start: tx=%b, required 0", tx);
    end
    repeat (17) tick();
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_bit3: tx=%b, required 0", tx);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_abort: tx=%b busy=%b, required tx=1 busy=0", tx, busy);
    end
    check_status(32'h2, "midrst");
    check_quiet(60, "midrst_no_frames");
    check_status(32'h2, "midrst_after");
  endtask

  initial begin
    repeat (2) tick();
    test_reset();
    test_single();
    test_back_to_back();
    test_no_effect();
    test_overflow();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_port.md
UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, 2..64.
REQ-003 Parameter ADDR_DATA, default 16'hFFFE, bus address of the transmit-data register.
REQ-004 Parameter ADDR_STAT, default 16'hFFFD, bus address of the status/control register.
REQ-005 Port clock, input, 1, the block's only clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clock.
REQ-007 Port address, input, 16, CPU bus address.
REQ-008 Port data, input, 32, CPU bus write data.
REQ-009 Port wren, input, 1, CPU bus write strobe, valid in the same cycle as address/data.
REQ-010 Port status, output, 32, read-back word for ADDR_STAT; combinational from registered state.
REQ-011 Port tx, output, 1, serial line, 8N1, LSB first, idle high; registered.
REQ-012 Port busy, output, 1, high while a frame is on the line or the FIFO is non-empty.

Function
REQ-013 A write is any cycle with wren=1 and address==ADDR_DATA; it SHALL push data[7:0] into the FIFO when the FIFO is not full.
REQ-014 A write while the FIFO is full SHALL be dropped without modifying the FIFO, and SHALL set the sticky overflow flag.
REQ-015 A cycle with wren=1, address==ADDR_STAT and data[3]=1 SHALL clear overflow; all other data bits of that write SHALL be ignored.
REQ-016 status SHALL equal {28'b0, overflow, full, empty, busy}; bits 31..4 SHALL be constant 0.
REQ-017 FIFO occupancy SHALL be a counter 0..FIFO_DEPTH; full = (count==FIFO_DEPTH) and empty = (count==0); read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The transmit FSM SHALL have states IDLE, START, DATA and STOP.
REQ-019 IDLE with FIFO non-empty SHALL pop one byte into the shift register and move to START; tx SHALL be driven low from the next edge.
REQ-020 START SHALL hold tx=0 for CLKS_PER_BIT cycles, then move to DATA.
REQ-021 DATA SHALL output bits 0..7 of the byte, each held CLKS_PER_BIT cycles, tracked by a 3-bit bit index, then move to STOP.
REQ-022 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles, then move to IDLE.
REQ-023 The frame length SHALL be exactly 10*CLKS_PER_BIT cycles; back-to-back bytes SHALL add exactly one IDLE cycle between the end of STOP and the next start bit.
REQ-024 Latency: a write sampled at edge E into an empty FIFO with the FSM in IDLE SHALL yield tx=0 after edge E+2.
REQ-025 A simultaneous push and pop while full SHALL accept the push: count is unchanged and no overflow occurs.
REQ-026 A simultaneous push and pop while empty is impossible, since the pop requires a registered non-empty condition.
REQ-027 Bus writes to any other address SHALL have no effect.

Reset
REQ-028 rst=1 at an edge SHALL force: FSM=IDLE, tx=1, count=0, pointers=0, overflow=0, baud counter=0, bit index=0; busy=0 and status=32'h2 from the next cycle.
REQ-029 rst asserted mid-frame SHALL abort the frame and drive tx high immediately after the reset edge, with no partial stop bit.
REQ-030 rst SHALL take priority over a concurrent bus write, and that write SHALL be lost.
REQ-031 FIFO storage contents need not be reset.

Structure
REQ-032 The state encoding and default address constants SHALL live in a shared package, coffee_io_pkg.
REQ-033 The FIFO SHALL be one sub-module, sync_fifo, parameterised by width (8) and depth, with push, pop, dout, full, empty and count ports.
REQ-034 The baud counter, bit index and FSM SHALL reside in uart_tx_port itself.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-035 Write 8'h55 after reset -> tx low 2 edges later, then the pattern 0,1,0,1,0,1,0,1,0,1, each value held 4 cycles (40 cycles total), then idle high; busy falls after STOP.
REQ-036 Write 8'hA3 then 8'h0F on consecutive cycles -> two frames, each 40 cycles, with exactly one idle-high cycle between them; data bits LSB first.
REQ-037 Write 6 bytes in 6 consecutive cycles -> first byte popped at cycle 2, 4 more queued, 6th dropped -> status bit 3=1; 5 frames transmitted.
REQ-038 Then write ADDR_STAT with data=32'h8 -> status bit 3=0, other bits unaffected.
REQ-039 Assert rst during data bit 3 of a frame with 2 bytes queued -> tx=1 next cycle, status=32'h2, no further frames.
REQ-040 Write to 16'hFFFF and to ADDR_STAT with data=32'h0 -> no FIFO change, tx stays high, status unchanged.
